// File: rtl/conv_seq_if.sv
// Control/status bundle between a layer scheduler (master) and the
// convolution-layer sequencer (slave).
interface conv_seq_if #(
    parameter int depth   = 2,
    parameter int ABuffer = 11
);
    logic                   start;
    logic [ABuffer-1:0]     kernelCount;
    logic [ABuffer-1:0]     outCount;
    logic [ABuffer-1:0]     readBase;
    logic [ABuffer-1:0]     writeBase;
    logic                   poolEnable;
    logic                   busy;
    logic                   done;
    logic                   kBuffWrite;
    logic [ABuffer-1:0]     kBuffAddress;
    logic [2*depth-1:0]     kernelDistControl;
    logic [ABuffer-1:0]     nReadAddress;
    logic [ABuffer-1:0]     nWriteAddress;
    logic                   nWriteEnable;
    logic [1:0]             convUnitControl;
    logic [1:0]             poolUnitControl;

    modport master (
        output start, kernelCount, outCount, readBase, writeBase, poolEnable,
        input  busy, done, kBuffWrite, kBuffAddress, kernelDistControl,
               nReadAddress, nWriteAddress, nWriteEnable,
               convUnitControl, poolUnitControl
    );

    modport slave (
        input  start, kernelCount, outCount, readBase, writeBase, poolEnable,
        output busy, done, kBuffWrite, kBuffAddress, kernelDistControl,
               nReadAddress, nWriteAddress, nWriteEnable,
               convUnitControl, poolUnitControl
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Sequences one convolution layer: kernel load, streaming conv reads,
// pipeline drain with delayed neuron write-back, then a done pulse.
module conv_layer_sequencer #(
    parameter int depth   = 2,
    parameter int D       = 1 << depth,
    parameter int ABuffer = 11,
    parameter int LAT     = 2
) (
    input  logic       clk,
    input  logic       rst,
    conv_seq_if.slave  bus
);
    localparam int DW      = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam int DD_MASK = D * D - 1;

    typedef enum logic [2:0] {IDLE, LOAD_K, CONV, DRAIN, FIN} state_t;

    state_t               state_reg, state_next;
    logic [ABuffer-1:0]   kernel_count_reg, out_count_reg, read_base_reg;
    logic                 pool_reg;
    logic [ABuffer-1:0]   k_cnt_reg, o_cnt_reg, r_addr_reg, w_addr_reg;
    logic [DW-1:0]        d_cnt_reg;
    logic [LAT-1:0]       valid_reg, valid_next;

    logic                 accept, k_last, o_last, d_last;
    logic [ABuffer-1:0]   conv_base;

    assign accept    = (state_reg == IDLE) && bus.start;
    assign k_last    = k_cnt_reg == kernel_count_reg - ABuffer'(1);
    assign o_last    = o_cnt_reg == out_count_reg - ABuffer'(1);
    assign d_last    = d_cnt_reg == DW'(LAT - 1);
    // Jumping straight from IDLE to CONV happens before the base is latched.
    assign conv_base = (state_reg == IDLE) ? bus.readBase : read_base_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.kernelCount != '0)   state_next = LOAD_K;
                    else if (bus.outCount != '0) state_next = CONV;
                    else                         state_next = FIN;
                end
            end
            LOAD_K: if (k_last) state_next = (out_count_reg != '0) ? CONV : FIN;
            CONV:   if (o_last) state_next = DRAIN;
            DRAIN:  if (d_last) state_next = FIN;
            FIN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy              = state_reg != IDLE;
        bus.done              = state_reg == FIN;
        bus.kBuffWrite        = state_reg == LOAD_K;
        bus.kernelDistControl = '0;
        bus.convUnitControl   = 2'b00;
        bus.poolUnitControl   = 2'b00;
        if (state_reg == LOAD_K)
            bus.kernelDistControl = k_cnt_reg[2*depth-1:0] & (2*depth)'(DD_MASK);
        if (state_reg == CONV)
            bus.convUnitControl = (o_cnt_reg == '0) ? 2'b10 : 2'b01;
        if ((state_reg == CONV || state_reg == DRAIN) && pool_reg)
            bus.poolUnitControl = 2'b01;
    end

    assign bus.kBuffAddress  = k_cnt_reg;
    assign bus.nReadAddress  = r_addr_reg;
    assign bus.nWriteAddress = w_addr_reg;
    assign bus.nWriteEnable  = valid_reg[LAT-1];

    // Each CONV read launches a token that emerges as a write LAT cycles later.
    assign valid_next[0] = state_reg == CONV;
    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_valid
            assign valid_next[gi] = valid_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_reg <= '0;
        else     valid_reg <= valid_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_count_reg <= '0;
            out_count_reg    <= '0;
            read_base_reg    <= '0;
            pool_reg         <= 1'b0;
            k_cnt_reg        <= '0;
            o_cnt_reg        <= '0;
            r_addr_reg       <= '0;
            w_addr_reg       <= '0;
            d_cnt_reg        <= '0;
        end else begin
            if (accept) begin
                kernel_count_reg <= bus.kernelCount;
                out_count_reg    <= bus.outCount;
                read_base_reg    <= bus.readBase;
                pool_reg         <= bus.poolEnable;
            end

            // Addresses reload only on entry so they hold their last value elsewhere.
            if (state_reg != LOAD_K && state_next == LOAD_K)
                k_cnt_reg <= '0;
            else if (state_reg == LOAD_K && !k_last)
                k_cnt_reg <= k_cnt_reg + ABuffer'(1);

            if (state_reg != CONV && state_next == CONV) begin
                o_cnt_reg  <= '0;
                r_addr_reg <= conv_base;
            end else if (state_reg == CONV && !o_last) begin
                o_cnt_reg  <= o_cnt_reg + ABuffer'(1);
                r_addr_reg <= r_addr_reg + ABuffer'(1);
            end

            if (state_reg != DRAIN && state_next == DRAIN)
                d_cnt_reg <= '0;
            else if (state_reg == DRAIN && !d_last)
                d_cnt_reg <= d_cnt_reg + DW'(1);

            if (accept)
                w_addr_reg <= bus.writeBase;
            else if (valid_reg[LAT-1])
                w_addr_reg <= w_addr_reg + ABuffer'(1);
        end
    end
endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameter depth, default 2, log2 of kernel-distribution lane count.
REQ-002 Parameter D, default 1<<depth, kernel-distribution lane count.
REQ-003 Parameter ABuffer, default 11, buffer address width.
REQ-004 Parameter LAT, default 2, conv-plus-pool datapath latency in cycles (LAT >= 1).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle layer launch request.
REQ-008 kernelCount  input  ABuffer  kernel words to load.
REQ-009 outCount  input  ABuffer  output pixels to compute.
REQ-010 readBase / writeBase  input  ABuffer each  first neuron read / write address.
REQ-011 poolEnable  input  1  route conv results through the pool unit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 kBuffWrite  output  1  kernel buffer write strobe.
REQ-015 kBuffAddress  output  ABuffer  kernel buffer address.
REQ-016 kernelDistControl  output  2*depth  kernel lane select.
REQ-017 nReadAddress / nWriteAddress  output  ABuffer each  neuron buffer addresses.
REQ-018 nWriteEnable  output  1  neuron buffer write strobe.
REQ-019 convUnitControl / poolUnitControl  output  2 each  datapath opcodes.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD_K, CONV, DRAIN, FIN.
REQ-021 From IDLE, start=1 SHALL latch all count/base/poolEnable inputs and go to LOAD_K, or to CONV if kernelCount=0, or to FIN if both counts are 0.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 LOAD_K SHALL last exactly kernelCount cycles, with kBuffWrite=1 and kBuffAddress = 0,1,...,kernelCount-1.
REQ-024 In LOAD_K, kernelDistControl SHALL equal kBuffAddress modulo D*D (wraps every D*D words); it SHALL be 0 outside LOAD_K.
REQ-025 After LOAD_K, the FSM SHALL go to CONV, or to FIN if outCount=0.
REQ-026 CONV SHALL last exactly outCount cycles, with nReadAddress = readBase + i (i = 0..outCount-1), modulo 2^ABuffer.
REQ-027 convUnitControl SHALL be 2'b10 (clear+accumulate) on the first CONV cycle, 2'b01 on the remaining CONV cycles, and 2'b00 elsewhere.
REQ-028 poolUnitControl SHALL be 2'b01 during CONV and DRAIN when the latched poolEnable=1, and 2'b00 otherwise.
REQ-029 nWriteEnable SHALL assert exactly LAT cycles after each CONV read cycle, via a LAT-deep valid shift register.
REQ-030 nWriteAddress SHALL start at writeBase and increment by 1 (mod 2^ABuffer) after each cycle with nWriteEnable=1.
REQ-031 DRAIN SHALL last exactly LAT cycles after the last CONV cycle, then go to FIN.
REQ-032 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-033 Total write count SHALL equal outCount; no write SHALL occur outside CONV/DRAIN/FIN.
REQ-034 nReadAddress and kBuffAddress SHALL hold their last value when not being driven in their active state.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, clear the valid shift register, and drive all outputs to 0, including mid-layer.
REQ-036 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-037 kernelCount=20, outCount=0 -> kBuffWrite high for 20 cycles, kernelDistControl 0..15,0..3, then done one cycle later.
REQ-038 kernelCount=0, outCount=5, readBase=2045, writeBase=100, LAT=2 -> reads 2045,2046,2047,0,1; writes 100..104 each 2 cycles after its read; convUnitControl 10,01,01,01,01.
REQ-039 poolEnable=1, kernelCount=3, outCount=4 -> poolUnitControl=01 for 4+LAT cycles; done pulses 3+4+LAT cycles after leaving IDLE.
REQ-040 Both counts 0 -> done pulses the cycle after start; no strobes.
REQ-041 start re-pulsed during CONV -> ignored; exactly one done pulse.
REQ-042 rst asserted in the 3rd CONV cycle -> all outputs 0 asynchronously; no further nWriteEnable; a new layer then completes correctly.
